// File: rtl/fb_pkg.sv
// Shared framebuffer constants and the writer state encoding.
package fb_pkg;

  localparam int FB_DATA_WIDTH   = 20;
  localparam int FB_ADDR_WIDTH   = 14;
  localparam int FB_FRAME_PIXELS = 16384;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITE     = 2'd1,
    WAIT_SWAP = 2'd2
  } fb_state_t;

endpackage

// File: rtl/fb_writer.sv
// Back-buffer write stage: turns an SOF-marked pixel stream into linear
// framebuffer writes and flips the buffer selection on the display's frame
// boundary once a full frame has landed.
module fb_writer
  import fb_pkg::*;
#(
  parameter int DATA_WIDTH   = FB_DATA_WIDTH,
  parameter int ADDR_WIDTH   = FB_ADDR_WIDTH,
  parameter int FRAME_PIXELS = FB_FRAME_PIXELS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  input  logic                  s_sof,
  output logic                  s_ready,
  input  logic                  frame_sync,
  output logic [DATA_WIDTH-1:0] fb_wdata,
  output logic [ADDR_WIDTH-1:0] fb_waddr,
  output logic                  fb_we,
  output logic                  selection,
  output logic                  swap_pulse,
  output logic                  sof_err
);

  // One extra bit so a frame of exactly 2**ADDR_WIDTH pixels is representable.
  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_PIXELS - 1);

  fb_state_t             state, state_next;
  logic [CW-1:0]         cnt, cnt_next;
  logic                  ready_next;
  logic                  we_next;
  logic [ADDR_WIDTH-1:0] waddr_next;
  logic [DATA_WIDTH-1:0] wdata_next;
  logic                  sel_next;
  logic                  swap_next;
  logic                  err_next;
  logic                  accept;

  assign accept = s_valid & s_ready;

  // Next-state, counter and registered-output decode.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    we_next    = 1'b0;
    waddr_next = fb_waddr;
    wdata_next = fb_wdata;
    sel_next   = selection;
    swap_next  = 1'b0;
    err_next   = 1'b0;
    case (state)
      IDLE: begin
        // Anything before the first SOF is dropped on the floor.
        if (accept && s_sof) begin
          we_next    = 1'b1;
          waddr_next = '0;
          wdata_next = s_data;
          cnt_next   = CW'(1);
          state_next = WRITE;
        end
      end
      WRITE: begin
        if (accept) begin
          we_next    = 1'b1;
          wdata_next = s_data;
          if (s_sof) begin
            // Early SOF: restart the frame from address 0 and flag it.
            waddr_next = '0;
            cnt_next   = CW'(1);
            err_next   = 1'b1;
          end else begin
            waddr_next = cnt[ADDR_WIDTH-1:0];
            if (cnt == LAST_IDX) begin
              cnt_next   = '0;
              state_next = WAIT_SWAP;
            end else begin
              cnt_next = cnt + CW'(1);
            end
          end
        end
      end
      WAIT_SWAP: begin
        // Entering this state one edge after the last acceptance guarantees
        // the final write has retired before selection can move.
        if (frame_sync) begin
          sel_next   = ~selection;
          swap_next  = 1'b1;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
    ready_next = (state_next != WAIT_SWAP);
  end

  // State, counter and all outputs are registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      s_ready    <= 1'b0;
      fb_we      <= 1'b0;
      fb_waddr   <= '0;
      fb_wdata   <= '0;
      selection  <= 1'b0;
      swap_pulse <= 1'b0;
      sof_err    <= 1'b0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      s_ready    <= ready_next;
      fb_we      <= we_next;
      fb_waddr   <= waddr_next;
      fb_wdata   <= wdata_next;
      selection  <= sel_next;
      swap_pulse <= swap_next;
      sof_err    <= err_next;
    end
  end

endmodule

// File: tb/tb_fb_writer.sv
// Randomised scoreboard bench for fb_writer with a 16-pixel frame.
module tb_fb_writer;

  localparam int DW = 20;
  localparam int AW = 4;
  localparam int FP = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_sof = 1'b0;
  logic          s_ready;
  logic          frame_sync = 1'b0;
  logic [DW-1:0] fb_wdata;
  logic [AW-1:0] fb_waddr;
  logic          fb_we;
  logic          selection;
  logic          swap_pulse;
  logic          sof_err;

  fb_writer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FRAME_PIXELS(FP)) dut (
    .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid),
    .s_sof(s_sof), .s_ready(s_ready), .frame_sync(frame_sync),
    .fb_wdata(fb_wdata), .fb_waddr(fb_waddr), .fb_we(fb_we),
    .selection(selection), .swap_pulse(swap_pulse), .sof_err(sof_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          err;
  } wr_t;

  wr_t q[$];
  int  tests = 0;
  int  fails = 0;
  int  writes_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: frame position is -1 outside a frame, 0..FP-1 inside,
  // and "waiting" means a whole frame is held for the next display sync.
  int   pos = -1;
  bit   waiting = 0;
  logic e_ready = 0, e_sel = 0, e_swap = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos = -1; waiting = 0; e_ready = 0; e_sel = 0; e_swap = 0;
      q.delete();
    end else begin
      bit acc;
      acc    = s_valid && e_ready;
      e_swap = 0;
      if (waiting) begin
        if (frame_sync) begin
          e_sel   = ~e_sel;
          e_swap  = 1;
          waiting = 0;
          pos     = -1;
        end
      end else if (acc) begin
        if (s_sof) begin
          q.push_back('{addr: '0, data: s_data, err: (pos >= 0)});
          pos = 1;
        end else if (pos >= 0) begin
          q.push_back('{addr: AW'(pos), data: s_data, err: 1'b0});
          pos++;
          if (pos == FP) begin
            waiting = 1;
            pos     = -1;
          end
        end
      end
      e_ready = !waiting;
    end
  end

  // Monitor: compares every cycle away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      check("s_ready", 32'(s_ready), 32'(e_ready));
      check("selection", 32'(selection), 32'(e_sel));
      check("swap_pulse", 32'(swap_pulse), 32'(e_swap));
      check("fb_we", 32'(fb_we), 32'(q.size() > 0));
      if (fb_we && q.size() > 0) begin
        wr_t w;
        w = q.pop_front();
        writes_seen++;
        check("fb_waddr", 32'(fb_waddr), 32'(w.addr));
        check("fb_wdata", 32'(fb_wdata), 32'(w.data));
        check("sof_err", 32'(sof_err), 32'(w.err));
        $display("[TB] write addr=%0d data=%05h sof_err=%0b sel=%0b", fb_waddr, fb_wdata, sof_err, selection);
      end else if (!fb_we) begin
        check("sof_err_idle", 32'(sof_err), 32'd0);
      end
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      s_valid    = 1'b0;
      s_sof      = 1'($urandom);
      s_data     = DW'($urandom);
      frame_sync = 1'b0;
    end
  endtask

  // Present one pixel until accepted; fs drives frame_sync alongside it.
  task automatic send(input logic [DW-1:0] d, input logic sof, input int gap, input logic fs);
    logic r;
    int   n;
    if (gap > 0) idle(gap);
    s_valid = 1'b1; s_data = d; s_sof = sof; frame_sync = fs;
    n = 0;
    do begin
      @(negedge clk); r = s_ready;
      @(posedge clk); #1;
      frame_sync = 1'b0;
      n++;
    end while (!r && n < 50);
    if (!r) check("accept_timeout", 32'(n), 32'd0);
    s_valid = 1'b0;
    s_sof   = 1'($urandom);
  endtask

  task automatic sync_pulse;
    frame_sync = 1'b1;
    @(posedge clk); #1;
    frame_sync = 1'b0;
  endtask

  task automatic frame(input logic [DW-1:0] base, input bit rnd);
    for (int i = 0; i < FP; i++) begin
      if (rnd)
        send(base + DW'(i), (i == 0), $urandom_range(0, 2),
             (i == FP-1) ? 1'b1 : 1'($urandom_range(0, 3) == 0));
      else
        send(base + DW'(i), (i == 0), 0, 1'b0);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_s_ready"}, 32'(s_ready), 32'd0);
    check({tag, "_fb_we"}, 32'(fb_we), 32'd0);
    check({tag, "_fb_waddr"}, 32'(fb_waddr), 32'd0);
    check({tag, "_fb_wdata"}, 32'(fb_wdata), 32'd0);
    check({tag, "_selection"}, 32'(selection), 32'd0);
    check({tag, "_swap_pulse"}, 32'(swap_pulse), 32'd0);
    check({tag, "_sof_err"}, 32'(sof_err), 32'd0);
  endtask

  initial begin
    #1 check_reset_outputs("reset");
    #21 rst_n = 1'b1;
    idle(2);

    // Plain frame, sync five cycles after last acceptance, then a second frame.
    frame(20'h00100, 0);
    idle(4); sync_pulse();
    idle(2);
    frame(20'h00100, 0);
    idle(4); sync_pulse();
    idle(2);

    // Pre-SOF garbage is discarded.
    for (int i = 0; i < 3; i++) send(20'hBAD00 + DW'(i), 1'b0, 0, 1'b0);
    frame(20'h00200, 0);
    idle(3); sync_pulse(); idle(2);

    // Mid-frame SOF at index 7 restarts the frame.
    for (int i = 0; i < 7; i++) send(20'h00300 + DW'(i), (i == 0), 0, 1'b0);
    frame(20'h00400, 0);
    idle(3); sync_pulse(); idle(2);

    // Random gaps, syncs during WRITE and coincident with the last pixel.
    for (int f = 0; f < 3; f++) begin
      frame(DW'($urandom), 1);
      idle($urandom_range(1, 4)); sync_pulse(); idle(2);
    end

    // Make sure selection is 1 before the mid-frame reset.
    if (e_sel == 1'b0) begin
      frame(20'h00500, 0);
      idle(2); sync_pulse(); idle(2);
    end
    check("sel_before_reset", 32'(selection), 32'd1);
    for (int i = 0; i < 9; i++) send(20'h00600 + DW'(i), (i == 0), 0, 1'b0);
    s_valid = 1'b1; s_data = 20'h00609; s_sof = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("midrst");
    @(posedge clk); #1;
    check_reset_outputs("midrst_hold");
    s_valid = 1'b0;
    @(negedge clk); #2 rst_n = 1'b1;
    idle(2);
    frame(20'h00700, 0);
    idle(3); sync_pulse(); idle(3);

    check("queue_drained", 32'(q.size()), 32'd0);
    check("writes_seen_min", 32'(writes_seen >= 8*FP), 32'd1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: time %0t limit 200000", $time);
    $fatal(1);
  end

endmodule

// File: doc/fb_writer.md
Name: fb_writer

Overview:
- Upstream write stage for the double-buffered pixel framebuffer.
- Accepts a valid/ready pixel stream with a start-of-frame marker and generates linear write addresses and write strobes into the back buffer.
- Holds a completed frame until the display side signals a frame boundary, then toggles the buffer selection so the new frame becomes visible without tearing.

Parameters:
- DATA_WIDTH, 20, pixel word width; matches the framebuffer data width.
- ADDR_WIDTH, 14, framebuffer address width.
- FRAME_PIXELS, 16384, pixels per frame. Range 2..2**ADDR_WIDTH.

Ports:
- clk  in  1  single clock for stream, framebuffer write port and swap logic.
- rst_n  in  1  asynchronous active-low reset.
- s_data  in  DATA_WIDTH  pixel data.
- s_valid  in  1  pixel valid.
- s_sof  in  1  qualifies s_data as the first pixel of a frame; sampled only when s_valid=1.
- s_ready  out  1  stage can accept a pixel.
- frame_sync  in  1  one-cycle pulse from the display side at its frame boundary, already in the clk domain.
- fb_wdata  out  DATA_WIDTH  framebuffer write data.
- fb_waddr  out  ADDR_WIDTH  framebuffer write address.
- fb_we  out  1  framebuffer write enable.
- selection  out  1  buffer select to the framebuffer.
- swap_pulse  out  1  one-cycle pulse in the cycle after selection toggles.
- sof_err  out  1  one-cycle pulse when s_sof arrives mid-frame.

Behaviour:
- Reset values: s_ready=0, fb_we=0, fb_waddr=0, fb_wdata=0, selection=0, swap_pulse=0, sof_err=0, state=IDLE, pixel counter=0. Reset is asynchronous and may occur mid-frame. The partially written frame is abandoned, selection returns to 0, and there is no further write.
- Handshake: a pixel is accepted when s_valid & s_ready at the rising clk edge.
- s_ready is a registered output, high in IDLE and WRITE and low in WAIT_SWAP. It goes high on the first clk after reset deasserts.
- Write latency: every accepted pixel produces exactly one fb_we=1 cycle on the next cycle, with fb_wdata set to the accepted data and fb_waddr set to the pixel index. fb_we is otherwise 0.
- State IDLE:
  - An accepted pixel with s_sof=0 is discarded (no write).
  - An accepted pixel with s_sof=1 is written to address 0, the counter becomes 1, and the next state is WRITE.
- State WRITE:
  - An accepted pixel with s_sof=0 is written to address counter, then the counter increments.
  - When the accepted pixel is index FRAME_PIXELS-1, the counter clears and the next state is WAIT_SWAP. s_ready is low from the following cycle.
  - An accepted pixel with s_sof=1 restarts the frame: it is written to address 0, the counter becomes 1, and sof_err pulses for one cycle, coincident with that pixel's fb_we. The state stays WRITE.
  - frame_sync is ignored in WRITE.
- State WAIT_SWAP:
  - No acceptance.
  - On the first frame_sync=1 sampled in this state, selection inverts at that edge and the next state is IDLE.
  - swap_pulse is high the cycle after the toggle; s_ready is high from the same cycle.
  - A frame_sync coincident with the final pixel acceptance (still in WRITE) does not count; the block waits for the next one.
- Ordering guarantee: fb_we is never high in the same cycle selection changes. The last write of a frame occurs at least 1 cycle before the toggle.
- Arithmetic:
  - The counter is ADDR_WIDTH+1 bits internally, so FRAME_PIXELS=2**ADDR_WIDTH is legal.
  - fb_waddr is the low ADDR_WIDTH bits.
  - The counter never exceeds FRAME_PIXELS-1 at a write.
- s_data and s_sof with s_valid=0 are don't-care and must not affect state.

Decomposition:
- Shared package (fb_pkg):
  - FB_DATA_WIDTH=20, FB_ADDR_WIDTH=14, FB_FRAME_PIXELS=16384, reused by this block, the framebuffer and the display reader.
  - State enum: IDLE=2'd0, WRITE=2'd1, WAIT_SWAP=2'd2.
- Single flat module; no sub-module is natural. The counter plus FSM stays under 200 lines.

Test Plan:
- Reset then stream FRAME_PIXELS=16 test frame:
  - Stimulus: pixel i = 20'h00100+i, s_sof on i=0, s_valid held high.
  - Response: fb_we high 16 consecutive cycles, fb_waddr 0..15, fb_wdata matching; s_ready low after the 16th acceptance; selection stays 0.
- frame_sync after the completed frame:
  - Stimulus: pulse frame_sync 5 cycles after the last acceptance.
  - Response: selection 0->1 on that edge, swap_pulse 1 cycle later, s_ready high; a second identical frame returns selection to 0.
- Pre-SOF garbage:
  - Stimulus: 3 valid pixels with s_sof=0 in IDLE, then an SOF frame.
  - Response: no fb_we for the garbage; first write at address 0 with the SOF data.
- Mid-frame SOF:
  - Stimulus: s_sof at pixel index 7 of a frame.
  - Response: sof_err pulses once; that pixel is written to address 0; the frame completes after 16 more acceptances (addresses 0..15).
- Backpressure and sync edge cases:
  - Stimulus: random s_valid gaps, frame_sync pulses during WRITE, and frame_sync coincident with the final acceptance.
  - Response: no toggle until the first frame_sync sampled in WAIT_SWAP; addresses contiguous despite gaps.
- Reset mid-frame:
  - Stimulus: assert rst_n=0 asynchronously at pixel 9 while selection=1.
  - Response: all outputs reach reset values immediately with no further fb_we; the next SOF frame writes from address 0 with selection=0.
